// File: rtl/ddl_reader_pkg.sv
// ddl_reader_pkg: types and constants shared by the DDL event reader and its
// skid FIFO.
package ddl_reader_pkg;

  // Reader sequencing states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    READ     = 3'd2,
    DRAIN    = 3'd3,
    CONFIRM  = 3'd4,
    WAIT_CLR = 3'd5
  } state_t;

  // Tag byte at the top of a per-channel trailer word.
  localparam logic [7:0] TRAILER_TAG = 8'hCA;

  // Bit of a RAM word that marks the last word of a channel.
  localparam int LAST_BIT = 32;

  // Width of the payload part of a RAM word and of the DDL data bus.
  localparam int PAYLOAD_W = 32;

endpackage

// File: rtl/ddl_skid_fifo.sv
// ddl_skid_fifo: 2-entry FIFO between the channel RAM read port and the DDL.
// Two entries are enough to hold one word that is already on the RAM output
// and one word that is still being read when the link raises xoff.
module ddl_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; a push into a full FIFO only lands when
  // the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ddl_event_reader.sv
// ddl_event_reader: reads one partition event out of the per-channel DTC RAMs
// and streams it onto the DDL. Channels are visited in ascending index order,
// each read from address 0 upward until its last-flag word.
// Build option: define DDL_CHAN_TRAILER_EN to append a trailer word
// {CA, channel, word count} after every channel.
//
// state    | meaning
// IDLE     | waiting for event_rdy, mask latched on entry to SCAN
// SCAN     | pick lowest pending channel, or finish if none left
// READ     | issue RAM reads while the skid FIFO has room
// DRAIN    | channel done; wait for FIFO to empty (trailer pushed first)
// CONFIRM  | every channel read, read_confirm pulses on exit
// WAIT_CLR | hold until event_rdy drops so the event is not re-read
module ddl_event_reader
  import ddl_reader_pkg::*;
#(
  parameter int NCH = 20,
  parameter int AW  = 10,
  parameter int DW  = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_rdy,
  input  logic [NCH-1:0]    ch_rdy,
  output logic [NCH-1:0]    ram_en,
  output logic [AW-1:0]     ram_addr,
  input  logic [NCH*DW-1:0] ram_dout,
  output logic              read_confirm,
  input  logic              ddl_xoff,
  output logic [31:0]       ddl_data,
  output logic              ddl_valid,
  output logic              ddl_eoe,
  output logic              busy,
  output logic              ovf_err
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW  = PAYLOAD_W + 1;

  state_t         state;
  state_t         state_nx;
  logic [NCH-1:0] mask;
  logic [CHW-1:0] ch;
  logic [CHW-1:0] low_idx;
  logic           inflight;
  logic           inflight_max;
  logic           addr_end;
  logic [DW-1:0]  rd_word;
  logic           rd_last;
  logic           ending;
  logic           issue;
  logic           space_ok;
  logic           mask_last;
  logic           fifo_push;
  logic           fifo_pop;
  logic [FW-1:0]  fifo_wdata;
  logic [FW-1:0]  fifo_head;
  logic [1:0]     fifo_count;
  logic           fifo_empty;
`ifdef DDL_CHAN_TRAILER_EN
  logic [9:0]     word_cnt;
  logic           trailer_done;
  logic           trailer_push;
`endif

  // Word returned this cycle by the channel selected last cycle.
  assign rd_word = ram_dout[int'(ch) * DW +: DW];
  assign rd_last = rd_word[LAST_BIT];

  // A returning word closes the channel if it carries the last flag or was
  // read from the top address (no wrap past 2^AW-1).
  assign ending = inflight && (rd_last || inflight_max);

  // Mask bit of the current channel is already cleared, so an empty mask
  // means this channel is the final one of the event.
  assign mask_last = (mask == '0);

  // A read issued now lands next cycle; allow it only if the FIFO is then
  // guaranteed a free slot: count + in-flight - pop <= 1.
  assign space_ok = ({1'b0, fifo_count} + {2'b00, inflight}) <= (3'd1 + {2'b00, fifo_pop});

  assign fifo_empty = (fifo_count == 2'd0);
  assign ddl_valid  = !fifo_empty && !ddl_xoff;
  assign fifo_pop   = ddl_valid;
  assign ddl_data   = ddl_valid ? fifo_head[PAYLOAD_W-1:0] : '0;
  assign ddl_eoe    = ddl_valid && fifo_head[PAYLOAD_W];
  assign busy       = (state != IDLE);

  // Lowest pending channel in the latched mask.
  always_comb begin
    low_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        low_idx = CHW'(k);
      end
    end
  end

  // Next-state, read issue and FIFO push selection.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    ram_en     = '0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
`ifdef DDL_CHAN_TRAILER_EN
    trailer_push = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (event_rdy) begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        state_nx = (mask != '0) ? READ : CONFIRM;
      end
      READ: begin
        issue = !addr_end && !ending && space_ok;
        if (issue) begin
          ram_en[ch] = 1'b1;
        end
        if (inflight) begin
          fifo_push = 1'b1;
`ifdef DDL_CHAN_TRAILER_EN
          fifo_wdata = {1'b0, rd_word[PAYLOAD_W-1:0]};
`else
          fifo_wdata = {ending && mask_last, rd_word[PAYLOAD_W-1:0]};
`endif
        end
        if (ending) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
`ifdef DDL_CHAN_TRAILER_EN
        if (!trailer_done) begin
          trailer_push = (fifo_count != 2'd2) || fifo_pop;
          fifo_push    = trailer_push;
          fifo_wdata   = {mask_last, TRAILER_TAG, 3'b000, 5'(ch), 6'b000000, word_cnt};
        end else if (fifo_empty) begin
          state_nx = SCAN;
        end
`else
        if (fifo_empty) begin
          state_nx = SCAN;
        end
`endif
      end
      CONFIRM: begin
        state_nx = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!event_rdy) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register, channel bookkeeping, read address and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mask         <= '0;
      ch           <= '0;
      ram_addr     <= '0;
      inflight     <= 1'b0;
      inflight_max <= 1'b0;
      addr_end     <= 1'b0;
      read_confirm <= 1'b0;
      ovf_err      <= 1'b0;
`ifdef DDL_CHAN_TRAILER_EN
      word_cnt     <= '0;
      trailer_done <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      read_confirm <= (state == CONFIRM);
      inflight     <= issue;
      inflight_max <= issue && (ram_addr == '1);

      if (state == IDLE && event_rdy) begin
        mask <= ch_rdy;
      end

      if (state == SCAN && mask != '0) begin
        ch            <= low_idx;
        mask[low_idx] <= 1'b0;
        ram_addr      <= '0;
        addr_end      <= 1'b0;
`ifdef DDL_CHAN_TRAILER_EN
        word_cnt      <= '0;
        trailer_done  <= 1'b0;
`endif
      end

      if (issue) begin
        if (ram_addr == '1) begin
          addr_end <= 1'b1;
        end else begin
          ram_addr <= ram_addr + 1'b1;
        end
      end

      if (state == READ && inflight && inflight_max && !rd_last) begin
        ovf_err <= 1'b1;
      end

`ifdef DDL_CHAN_TRAILER_EN
      if (state == READ && inflight) begin
        word_cnt <= word_cnt + 10'd1;
      end
      if (trailer_push) begin
        trailer_done <= 1'b1;
      end
`endif
    end
  end

  ddl_skid_fifo #(
    .W (FW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ddl_event_reader.sv
// tb_ddl_event_reader: directed bench for ddl_event_reader with a behavioural
// 1-cycle-latency RAM per channel and a capture queue on the DDL side.
// Build option: DDL_CHAN_TRAILER_EN adds the expected trailer words.
module tb_ddl_event_reader;

  localparam int NCH = 20;
  localparam int AW  = 10;
  localparam int DW  = 33;

  logic              clk = 1'b0;
  logic              reset;
  logic              event_rdy;
  logic [NCH-1:0]    ch_rdy;
  logic [NCH-1:0]    ram_en;
  logic [AW-1:0]     ram_addr;
  logic [NCH*DW-1:0] ram_dout;
  logic              read_confirm;
  logic              ddl_xoff;
  logic [31:0]       ddl_data;
  logic              ddl_valid;
  logic              ddl_eoe;
  logic              busy;
  logic              ovf_err;

  logic [DW-1:0] ram [NCH][1 << AW];
  logic [32:0]   cap [$];
  logic [32:0]   exp_q [$];
  int            rc_count  = 0;
  int            xoff_viol = 0;
  int            checks    = 0;
  int            errors    = 0;
  int            rc0;

  ddl_event_reader #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .event_rdy    (event_rdy),
    .ch_rdy       (ch_rdy),
    .ram_en       (ram_en),
    .ram_addr     (ram_addr),
    .ram_dout     (ram_dout),
    .read_confirm (read_confirm),
    .ddl_xoff     (ddl_xoff),
    .ddl_data     (ddl_data),
    .ddl_valid    (ddl_valid),
    .ddl_eoe      (ddl_eoe),
    .busy         (busy),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  // Channel RAMs: registered read, one clock of latency.
  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (ram_en[k]) ram_dout[k*DW +: DW] <= ram[k][ram_addr];
    end
  end

  // DDL-side monitor.
  always @(negedge clk) begin
    if (ddl_valid) cap.push_back({ddl_eoe, ddl_data});
    if (read_confirm) rc_count++;
    if (ddl_valid && ddl_xoff) xoff_viol++;
  end

  function automatic logic [31:0] wd(input int c, input int a);
    return {8'hA5, 3'b000, 5'(c), 16'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int c, input int n, input bit with_last);
    for (int i = 0; i < n; i++) ram[c][i] = {with_last && (i == n - 1), wd(c, i)};
  endtask

  task automatic exp_chan(input int c, input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
`ifdef DDL_CHAN_TRAILER_EN
      exp_q.push_back({1'b0, wd(c, i)});
`else
      exp_q.push_back({fin && (i == n - 1), wd(c, i)});
`endif
    end
`ifdef DDL_CHAN_TRAILER_EN
    exp_q.push_back({fin, 8'hCA, 3'b000, 5'(c), 6'b000000, 10'(n)});
`endif
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(cap[i]), 64'(exp_q[i]));
  endtask

  task automatic wait_words(input int n, input int bound, input string tag);
    int i = 0;
    while (cap.size() < n && i < bound) begin
      sample();
      i++;
    end
    chk(tag, 64'(cap.size() >= n), 64'd1);
  endtask

  task automatic wait_rc(input int base, input int bound, input string tag);
    int i = 0;
    while (rc_count <= base && i < bound) begin
      sample();
      i++;
    end
    chk(tag, 64'(rc_count > base), 64'd1);
  endtask

  task automatic finish_event(input string tag);
    event_rdy = 1'b0;
    step();
    sample();
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic start(input logic [NCH-1:0] m);
    cap.delete();
    exp_q.delete();
    rc0       = rc_count;
    ch_rdy    = m;
    event_rdy = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    event_rdy = 1'b0;
    ch_rdy    = '0;
    ddl_xoff  = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < (1 << AW); a++) ram[c][a] = '0;
    load(0, 3, 1'b1);
    load(1, 2, 1'b1);
    load(2, 1, 1'b1);
    load(5, 8, 1'b1);
    load(19, 1 << AW, 1'b0);
    load(7, 16, 1'b1);
    load(3, 2, 1'b1);

    // Reset values.
    repeat (3) step();
    sample();
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_confirm", 64'(read_confirm), 64'd0);
    chk("rst_valid", 64'(ddl_valid), 64'd0);
    chk("rst_eoe", 64'(ddl_eoe), 64'd0);
    chk("rst_data", 64'(ddl_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    reset = 1'b0;
    step();

    // Channels 0 and 2; ch_rdy changes after the latch must be ignored.
    start(20'h00005);
    repeat (4) step();
    ch_rdy = '1;
    wait_rc(rc0, 200, "t1_confirm");
    finish_event("t1_busy_clr");
    ch_rdy = '0;
    exp_chan(0, 3, 1'b0);
    exp_chan(2, 1, 1'b1);
    check_stream("t1");
    chk("t1_rc_once", 64'(rc_count - rc0), 64'd1);

    // Empty mask: no data, read_confirm two clocks after the latch.
    sample();
    start('0);
    sample();
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_rc_e0", 64'(read_confirm), 64'd0);
    sample();
    chk("t2_rc_e1", 64'(read_confirm), 64'd0);
    sample();
    chk("t2_rc_e2", 64'(read_confirm), 64'd1);
    sample();
    chk("t2_rc_e3", 64'(read_confirm), 64'd0);
    repeat (5) sample();
    chk("t2_rc_once", 64'(rc_count - rc0), 64'd1);
    chk("t2_busy_hold", 64'(busy), 64'd1);
    chk("t2_no_words", 64'(cap.size()), 64'd0);
    event_rdy = 1'b0;
    sample();
    chk("t2_busy_clr", 64'(busy), 64'd0);

    // Channel 5, xoff for 5 clocks starting at the 2nd word.
    start(20'h00020);
    wait_words(1, 50, "t3_first");
    step();
    ddl_xoff = 1'b1;
    repeat (5) step();
    ddl_xoff = 1'b0;
    chk("t3_hold", 64'(cap.size()), 64'd1);
    wait_rc(rc0, 200, "t3_confirm");
    finish_event("t3_busy_clr");
    exp_chan(5, 8, 1'b1);
    check_stream("t3");
    chk("t3_xoff_valid", 64'(xoff_viol), 64'd0);

    // Channel 19 without a last flag: top address closes it and flags ovf.
    start(20'h80000);
    wait_rc(rc0, 3000, "t4_confirm");
    chk("t4_ovf", 64'(ovf_err), 64'd1);
    finish_event("t4_busy_clr");
    exp_chan(19, 1 << AW, 1'b1);
    check_stream("t4");

    // Reset for one clock in the middle of channel 7, then a full re-read.
    start(20'h00080);
    wait_words(3, 50, "t5_started");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cap.delete();
    sample();
    chk("t5_ram_en", 64'(ram_en), 64'd0);
    chk("t5_ram_addr", 64'(ram_addr), 64'd0);
    chk("t5_confirm", 64'(read_confirm), 64'd0);
    chk("t5_valid", 64'(ddl_valid), 64'd0);
    chk("t5_data", 64'(ddl_data), 64'd0);
    chk("t5_eoe", 64'(ddl_eoe), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ovf", 64'(ovf_err), 64'd0);
    chk("t5_no_rc", 64'(rc_count - rc0), 64'd0);
    wait_rc(rc0, 300, "t5_confirm");
    finish_event("t5_busy_clr");
    exp_chan(7, 16, 1'b1);
    check_stream("t5");
    chk("t5_rc_once", 64'(rc_count - rc0), 64'd1);

    // Channel 3 with two words.
    start(20'h00008);
    wait_rc(rc0, 200, "t6_confirm");
    finish_event("t6_busy_clr");
`ifdef DDL_CHAN_TRAILER_EN
    chk("t6_trailer", 64'(cap[2]), {31'd0, 1'b1, 32'hCA030002});
`else
    chk("t6_last", 64'(cap[1]), {31'd0, 1'b1, 32'hA5030001});
`endif
    exp_chan(3, 2, 1'b1);
    check_stream("t6");
    chk("xoff_valid_all", 64'(xoff_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddl_event_reader.md
DDL_EVENT_READER -- requirements
Module: ddl_event_reader

Interface
REQ-001 SHALL have parameter NCH, default 20: number of DTC channel RAMs per partition.
REQ-002 SHALL have parameter AW, default 10: channel RAM address width.
REQ-003 SHALL have parameter DW, default 33: RAM word width; bit 32 is the last-word flag and bits 31:0 are the payload.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port event_rdy, input, 1: level; partition event stored in RAMs.
REQ-007 SHALL have port ch_rdy, input, NCH: per-channel event-ready mask.
REQ-008 SHALL have port ram_en, output, NCH: one-hot read enable.
REQ-009 SHALL have port ram_addr, output, AW: shared read address.
REQ-010 SHALL have port ram_dout, input, NCH*DW: concatenated RAM outputs, channel k at bits [k*DW +: DW]; read latency 1 clk.
REQ-011 SHALL have port read_confirm, output, 1: one-cycle pulse, event fully read.
REQ-012 SHALL have port ddl_xoff, input, 1: DDL backpressure.
REQ-013 SHALL have ports ddl_data (output, 32), ddl_valid (output, 1), ddl_eoe (output, 1): data stream, valid strobe and last-word-of-event marker.
REQ-014 SHALL have ports busy (output, 1) and ovf_err (output, 1): event in progress; sticky missing-last-flag error.

Function
REQ-015 SHALL implement states IDLE, SCAN, READ, DRAIN, CONFIRM, WAIT_CLR.
REQ-016 IDLE with event_rdy=1: latch ch_rdy into mask, set busy, go to SCAN.
REQ-017 SCAN: select lowest set mask bit, clear it, set ram_addr to 0, go to READ; if the mask is empty, go to CONFIRM.
REQ-018 READ: assert ram_en[ch] and increment ram_addr each cycle while the skid buffer has space; stop issuing reads while it is full.
REQ-019 A returned word with bit 32 set ends the channel: stop reads, drop the later in-flight word, go to DRAIN.
REQ-020 Address wrap: a read at address 2^AW-1 without the last flag ends the channel and sets ovf_err; the address shall not wrap.
REQ-021 DRAIN: on buffer empty, return to SCAN.
REQ-022 CONFIRM: pulse read_confirm for one clk, go to WAIT_CLR.
REQ-023 WAIT_CLR: on event_rdy=0, clear busy and go to IDLE; the same event shall never be read twice.
REQ-024 ddl_valid SHALL be 0 in every cycle where ddl_xoff=1; no words lost or duplicated across xoff of any length.
REQ-025 ddl_eoe SHALL be 1 with the final valid word of an event only; an event with an empty mask emits no words.
REQ-026 Channel output order SHALL be ascending index; words within a channel SHALL be in ascending address.
REQ-027 ch_rdy changes after the latch SHALL be ignored until the next IDLE.

Reset
REQ-028 Reset SHALL give state IDLE, ram_en=0, ram_addr=0, read_confirm=0, ddl_valid=0, ddl_eoe=0, ddl_data=0, busy=0, ovf_err=0, mask=0, skid buffer empty.
REQ-029 Reset mid-event SHALL abort with no read_confirm; after reset, a still-high event_rdy starts a fresh read.

Configuration
REQ-030 Macro DDL_CHAN_TRAILER_EN defined: after each channel's last word, emit a trailer {8'hCA, 3'b0, ch[4:0], 6'b0, count[9:0]}, where count is the number of data words, before leaving DRAIN; ddl_eoe then marks the final trailer.
REQ-031 Macro undefined: no trailer; the stream contains payload words only.

Structure
REQ-032 Shared package ddl_reader_pkg SHALL hold the state enum, the trailer tag 8'hCA and the last-flag bit index.
REQ-033 Sub-module ddl_skid_fifo SHALL be a 2-deep, 32+1-bit FIFO absorbing RAM latency under xoff.

Verification
REQ-034 mask=20'h00005; ch0 has 3 words, last at addr 2; ch2 has 1 word -> 4 words out in order, ddl_eoe on the 4th, one read_confirm.
REQ-035 mask=0, event_rdy=1 -> no ddl_valid, read_confirm 2 clks after latch, busy clears when event_rdy drops.
REQ-036 ch5 with 8 words; xoff high for 5 clks starting at the 2nd word -> exactly 8 words out, no valid during xoff.
REQ-037 ch19 has no last flag in 1024 words -> 1024 words out, ovf_err=1, read_confirm issued.
REQ-038 reset for 1 clk mid-READ -> all outputs at reset values next clk, no read_confirm; event re-read in full afterward.
REQ-039 TRAILER_EN, ch3 with 2 words -> 3rd word = 32'hCA030002 with ddl_eoe.
